cursor_overlay_ctrl: RTL and testbench
======================================

// Module: cursor_overlay_ctrl
// PURPOSE
//  Sequences the mouse-cursor layer for the per-pixel colour mux.
//  - Takes raw mouse-driver events and the VGA counters.
//  - Latches a frame-coherent cursor position and button state once per frame, at vblank entry.
//  - Generates a pipelined cursor-ROM address plus the aligned enable_mouse_display, valid_d and h_cnt_d.
//  - Holds per-button "flip" flags for a programmable number of frames after release.
//  - Sits between the mouse driver / VGA timing generator and pixel_gen.
// PARAMETERS
//  CURSOR_W    16   cursor sprite width, pixels (power of 2)
//  CURSOR_H    16   cursor sprite height, pixels
//  H_ACTIVE    640  visible pixels per line
//  V_ACTIVE    480  visible lines per frame
//  HOLD_FRAMES 4    frames a button flag persists after release (0 = none)
// PORTS
//  clk                   in   1   pixel clock
//  rst_n                 in   1   async active-low reset
//  h_cnt                 in   10  horizontal counter from VGA timing
//  v_cnt                 in   10  vertical counter from VGA timing
//  valid                 in   1   active-video flag from VGA timing
//  mouse_x               in   10  raw cursor X from mouse driver
//  mouse_y               in   10  raw cursor Y from mouse driver
//  mouse_left            in   1   left button level
//  mouse_right           in   1   right button level
//  mouse_event           in   1   1-cycle pulse: mouse_x/y/buttons updated
//  cursor_addr           out  $clog2(CURSOR_W*CURSOR_H)  sync cursor-ROM read address
//  enable_mouse_display  out  1   cursor pixel select, aligned with ROM data
//  valid_d               out  1   valid delayed to ROM-data alignment
//  h_cnt_d               out  10  h_cnt delayed to ROM-data alignment
//  frame_x               out  10  latched cursor X for current frame
//  frame_y               out  10  latched cursor Y for current frame
//  left_flag             out  1   left-button flip flag (pressed or holding)
//  right_flag            out  1   right-button flip flag (pressed or holding)
// BEHAVIOUR
//  Reset (async, rst_n=0):
//  - All outputs 0; pending regs 0; pending flag clear.
//  - Both button FSMs in IDLE; hold counters 0.
//  Event capture:
//  - mouse_event=1 -> pending_x/y/buttons <= inputs, pending <= 1.
//  - X is clamped to H_ACTIVE-1, Y to V_ACTIVE-1.
//  Frame boundary fb:
//  - One-cycle strobe on the first cycle with v_cnt==V_ACTIVE, h_cnt==0.
//  - Edge-detected; it never fires twice per frame.
//  - At fb with pending=1 -> frame_x/y and button snapshot <= pending values; pending <= 0.
//  - fb and mouse_event in the same cycle: fb commits the old pending values; the new event
//    loads pending and pending stays 1, so it is applied at the next fb.
//  - frame_x/y never change mid-frame.
//  Overlay pipeline (fixed latency 2, independent of FSMs):
//  - Stage 1 (registered):
//    - hit = valid && h_cnt in [frame_x, frame_x+CURSOR_W) && v_cnt in [frame_y, frame_y+CURSOR_H).
//    - Compares use 11-bit sums, so a cursor near the right/bottom edge is clipped, not wrapped.
//    - cursor_addr <= hit ? (v_cnt-frame_y)*CURSOR_W + (h_cnt-frame_x) : 0.
//  - Stage 2: enable_mouse_display <= hit_s1; valid_d, h_cnt_d are 2-cycle delays of valid, h_cnt.
//  - Result: ROM data for the pixel at cycle N appears with enable_mouse_display at N+2.
//  Button FSM (one per button; input = snapshot bit; updates only at fb):
//  - IDLE    : btn=1 -> PRESSED.
//  - PRESSED : btn=0 -> HOLD with cnt=HOLD_FRAMES; if HOLD_FRAMES==0 -> IDLE.
//  - HOLD    : btn=1 -> PRESSED; else cnt-1; reaching 0 -> IDLE.
//  - flag = (state != IDLE), registered; changes one cycle after fb.
//  Reset mid-frame: pipeline and latched position clear immediately; the first fb after reset
//  applies only events received after reset.
// TESTING
//  1 Reset: hold rst_n=0 for 5 cycles with random inputs -> all outputs 0, flags 0.
//  2 Coherency: event (100,50) at v_cnt=200 -> frame_x/y stay 0 until fb, then 100/50.
//    Next frame h=103,v=52 -> 2 cycles later enable_mouse_display=1, cursor_addr=35.
//  3 Edge clip: event (635,470) -> h=639,v=479 hits (addr=148); h=0,v=0 does not hit.
//    Event (700,900) -> frame_x=639, frame_y=479.
//  4 Simultaneous: event (10,10) then event (20,20) on the fb cycle ->
//    frame_x=10 this frame, 20 after the next fb.
//  5 Hold: left pressed 1 frame, then released -> left_flag=1 for exactly 1+4 frames.
//    Re-press during HOLD restarts; with HOLD_FRAMES=0 the flag drops at the release fb.
//  6 Latency: sweep a full frame vs a reference model ->
//    valid_d/h_cnt_d exactly 2 cycles behind; enable_mouse_display=0 whenever valid_d=0.

Source files
------------

// File: rtl/cursor_overlay_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : cursor_overlay_ctrl_if
// Description : Bundle of mouse-driver events, VGA timing counters and the
//               aligned cursor-layer outputs handed to pixel_gen.
// Revision    : 1.0 - initial release
// ============================================================================
interface cursor_overlay_ctrl_if #(
    parameter int ADDR_W = 8
);
    // VGA timing side
    logic [9:0]        h_cnt;
    logic [9:0]        v_cnt;
    logic              valid;
    // Mouse driver side
    logic [9:0]        mouse_x;
    logic [9:0]        mouse_y;
    logic              mouse_left;
    logic              mouse_right;
    logic              mouse_event;
    // Cursor layer outputs
    logic [ADDR_W-1:0] cursor_addr;
    logic              enable_mouse_display;
    logic              valid_d;
    logic [9:0]        h_cnt_d;
    logic [9:0]        frame_x;
    logic [9:0]        frame_y;
    logic              left_flag;
    logic              right_flag;

    // Cursor overlay controller view
    modport slave (
        input  h_cnt, v_cnt, valid,
        input  mouse_x, mouse_y, mouse_left, mouse_right, mouse_event,
        output cursor_addr, enable_mouse_display, valid_d, h_cnt_d,
        output frame_x, frame_y, left_flag, right_flag
    );

    // Driver / timing-generator view
    modport master (
        output h_cnt, v_cnt, valid,
        output mouse_x, mouse_y, mouse_left, mouse_right, mouse_event,
        input  cursor_addr, enable_mouse_display, valid_d, h_cnt_d,
        input  frame_x, frame_y, left_flag, right_flag
    );
endinterface
`default_nettype wire

// File: rtl/cursor_overlay_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cursor_overlay_ctrl
// Description : Frame-coherent mouse cursor sequencer. Captures driver events,
//               commits them at vblank entry, produces a 2-stage pipelined
//               cursor-ROM address with aligned select/valid/h_cnt, and keeps
//               per-button flip flags alive for HOLD_FRAMES after release.
// Revision    : 1.0 - initial release
// ============================================================================
module cursor_overlay_ctrl #(
    parameter int CURSOR_W    = 16,
    parameter int CURSOR_H    = 16,
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int HOLD_FRAMES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    cursor_overlay_ctrl_if.slave  bus
);

    localparam int ADDR_W = $clog2(CURSOR_W * CURSOR_H);
    localparam int DX_W   = $clog2(CURSOR_W);
    localparam int DY_W   = ADDR_W - DX_W;
    localparam int CNT_W  = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;

    localparam logic [9:0]  c_X_MAX   = 10'(H_ACTIVE - 1);
    localparam logic [9:0]  c_Y_MAX   = 10'(V_ACTIVE - 1);
    localparam logic [9:0]  c_FB_LINE = 10'(V_ACTIVE);
    localparam logic [10:0] c_W11     = 11'(CURSOR_W);
    localparam logic [10:0] c_H11     = 11'(CURSOR_H);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_HOLD    = 2'd2
    } btn_state_t;

    // Pending (not yet committed) event
    logic              r_pend;
    logic [9:0]        r_pend_x;
    logic [9:0]        r_pend_y;
    logic [1:0]        r_pend_btn;      // {right, left}

    // Frame-coherent state
    logic [9:0]        r_frame_x;
    logic [9:0]        r_frame_y;
    logic [1:0]        r_snap_btn;

    // Frame boundary detection
    logic              r_fb_cond_d;
    logic              w_fb_cond;
    logic              w_fb;

    // Overlay pipeline
    logic              r_hit_s1;
    logic              r_en;
    logic              r_valid_s1;
    logic              r_valid_d;
    logic [9:0]        r_h_s1;
    logic [9:0]        r_h_d;
    logic [ADDR_W-1:0] r_cursor_addr;

    logic [9:0]        w_clamp_x;
    logic [9:0]        w_clamp_y;
    logic [1:0]        w_btn_commit;
    logic              w_hit;
    logic [DX_W-1:0]   w_dx;
    logic [DY_W-1:0]   w_dy;
    logic [1:0]        w_flag;

    assign w_clamp_x = (bus.mouse_x > c_X_MAX) ? c_X_MAX : bus.mouse_x;
    assign w_clamp_y = (bus.mouse_y > c_Y_MAX) ? c_Y_MAX : bus.mouse_y;

    // Vblank entry; the delayed copy keeps a multi-cycle (V_ACTIVE,0) from strobing twice
    assign w_fb_cond = (bus.v_cnt == c_FB_LINE) && (bus.h_cnt == 10'd0);
    assign w_fb      = w_fb_cond && !r_fb_cond_d;

    // Button level the FSMs see at fb: freshly committed values win over the old snapshot
    assign w_btn_commit = r_pend ? r_pend_btn : r_snap_btn;

    // Edge detector register for the frame boundary strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_fb_cond_d <= 1'b0;
        else        r_fb_cond_d <= w_fb_cond;
    end

    // Event capture; a same-cycle event re-arms pending after fb has consumed the old one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend     <= 1'b0;
            r_pend_x   <= '0;
            r_pend_y   <= '0;
            r_pend_btn <= '0;
        end else if (bus.mouse_event) begin
            r_pend     <= 1'b1;
            r_pend_x   <= w_clamp_x;
            r_pend_y   <= w_clamp_y;
            r_pend_btn <= {bus.mouse_right, bus.mouse_left};
        end else if (w_fb) begin
            r_pend     <= 1'b0;
        end
    end

    // Commit pending position and buttons only at the frame boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_x  <= '0;
            r_frame_y  <= '0;
            r_snap_btn <= '0;
        end else if (w_fb && r_pend) begin
            r_frame_x  <= r_pend_x;
            r_frame_y  <= r_pend_y;
            r_snap_btn <= r_pend_btn;
        end
    end

    // 11-bit bounds so a cursor at the right/bottom edge clips instead of wrapping
    assign w_hit = bus.valid
                && (bus.h_cnt >= r_frame_x) && ({1'b0, bus.h_cnt} < ({1'b0, r_frame_x} + c_W11))
                && (bus.v_cnt >= r_frame_y) && ({1'b0, bus.v_cnt} < ({1'b0, r_frame_y} + c_H11));

    // CURSOR_W is a power of two, so row*W + col is a plain concatenation of low bits
    assign w_dx = bus.h_cnt[DX_W-1:0] - r_frame_x[DX_W-1:0];
    assign w_dy = bus.v_cnt[DY_W-1:0] - r_frame_y[DY_W-1:0];

    // Two-stage overlay pipeline: address at +1 (ROM read), select/valid/h_cnt at +2
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hit_s1      <= 1'b0;
            r_en          <= 1'b0;
            r_valid_s1    <= 1'b0;
            r_valid_d     <= 1'b0;
            r_h_s1        <= '0;
            r_h_d         <= '0;
            r_cursor_addr <= '0;
        end else begin
            r_hit_s1      <= w_hit;
            r_cursor_addr <= w_hit ? {w_dy, w_dx} : '0;
            r_en          <= r_hit_s1;
            r_valid_s1    <= bus.valid;
            r_valid_d     <= r_valid_s1;
            r_h_s1        <= bus.h_cnt;
            r_h_d         <= r_h_s1;
        end
    end

    // One press/hold FSM per button (bit 0 = left, bit 1 = right)
    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
        btn_state_t       r_state;
        btn_state_t       w_state_next;
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] w_cnt_next;
        logic             r_flag;

        // State, hold counter and registered flag
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
                r_flag  <= 1'b0;
            end else begin
                r_state <= w_state_next;
                r_cnt   <= w_cnt_next;
                r_flag  <= (w_state_next != ST_IDLE);
            end
        end

        // Next state evaluated once per frame, at the boundary strobe
        always_comb begin
            w_state_next = r_state;
            w_cnt_next   = r_cnt;
            if (w_fb) begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_btn_commit[gi]) w_state_next = ST_PRESSED;
                    end
                    ST_PRESSED: begin
                        if (!w_btn_commit[gi]) begin
                            if (HOLD_FRAMES == 0) begin
                                w_state_next = ST_IDLE;
                                w_cnt_next   = '0;
                            end else begin
                                w_state_next = ST_HOLD;
                                w_cnt_next   = CNT_W'(HOLD_FRAMES);
                            end
                        end
                    end
                    ST_HOLD: begin
                        if (w_btn_commit[gi]) begin
                            w_state_next = ST_PRESSED;
                            w_cnt_next   = '0;
                        end else if (r_cnt <= CNT_W'(1)) begin
                            w_state_next = ST_IDLE;
                            w_cnt_next   = '0;
                        end else begin
                            w_cnt_next   = r_cnt - CNT_W'(1);
                        end
                    end
                    default: begin
                        w_state_next = ST_IDLE;
                        w_cnt_next   = '0;
                    end
                endcase
            end
        end

        assign w_flag[gi] = r_flag;
    end

    assign bus.cursor_addr          = r_cursor_addr;
    assign bus.enable_mouse_display = r_en;
    assign bus.valid_d              = r_valid_d;
    assign bus.h_cnt_d              = r_h_d;
    assign bus.frame_x              = r_frame_x;
    assign bus.frame_y              = r_frame_y;
    assign bus.left_flag            = w_flag[0];
    assign bus.right_flag           = w_flag[1];

endmodule
`default_nettype wire

// File: tb/tb_cursor_overlay_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cursor_overlay_ctrl
// Description : Self-checking bench for cursor_overlay_ctrl. Two instances
//               (HOLD_FRAMES=4 and HOLD_FRAMES=0) share one stimulus stream;
//               a frame-level behavioural model supplies expected values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cursor_overlay_ctrl;

    localparam int HOLD_A = 4;
    localparam int HOLD_B = 0;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] h_cnt = '0;
    logic [9:0] v_cnt = '0;
    logic       valid = 1'b0;
    logic [9:0] mouse_x = '0;
    logic [9:0] mouse_y = '0;
    logic       mouse_left = 1'b0;
    logic       mouse_right = 1'b0;
    logic       mouse_event = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cursor_overlay_ctrl_if #(.ADDR_W(8)) bus0 ();
    cursor_overlay_ctrl_if #(.ADDR_W(8)) bus1 ();

    assign bus0.h_cnt = h_cnt;        assign bus1.h_cnt = h_cnt;
    assign bus0.v_cnt = v_cnt;        assign bus1.v_cnt = v_cnt;
    assign bus0.valid = valid;        assign bus1.valid = valid;
    assign bus0.mouse_x = mouse_x;    assign bus1.mouse_x = mouse_x;
    assign bus0.mouse_y = mouse_y;    assign bus1.mouse_y = mouse_y;
    assign bus0.mouse_left = mouse_left;   assign bus1.mouse_left = mouse_left;
    assign bus0.mouse_right = mouse_right; assign bus1.mouse_right = mouse_right;
    assign bus0.mouse_event = mouse_event; assign bus1.mouse_event = mouse_event;

    cursor_overlay_ctrl #(.HOLD_FRAMES(HOLD_A)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    cursor_overlay_ctrl #(.HOLD_FRAMES(HOLD_B)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    // ---------------- behavioural reference model ----------------
    int m_pend, m_px, m_py, m_pl, m_pr;
    int m_fx, m_fy, m_sl, m_sr, m_prevc;
    int m_pressed[2][2];   // [instance][button]
    int m_left[2][2];      // frames of hold remaining
    int p_hit, p_valid, p_h;
    int e_addr, e_en, e_vd, e_hd;
    int e_flag[2][2];

    task automatic model_reset();
        m_pend = 0; m_px = 0; m_py = 0; m_pl = 0; m_pr = 0;
        m_fx = 0; m_fy = 0; m_sl = 0; m_sr = 0; m_prevc = 0;
        p_hit = 0; p_valid = 0; p_h = 0;
        e_addr = 0; e_en = 0; e_vd = 0; e_hd = 0;
        for (int d = 0; d < 2; d++)
            for (int b = 0; b < 2; b++) begin
                m_pressed[d][b] = 0; m_left[d][b] = 0; e_flag[d][b] = 0;
            end
    endtask

    task automatic btn_update(input int d, input int b, input int btn);
        if (btn != 0) begin
            m_pressed[d][b] = 1;
            m_left[d][b]    = 0;
        end else if (m_pressed[d][b] != 0) begin
            m_pressed[d][b] = 0;
            m_left[d][b]    = (d == 0) ? HOLD_A : HOLD_B;
        end else if (m_left[d][b] > 0) begin
            m_left[d][b]    = m_left[d][b] - 1;
        end
        e_flag[d][b] = (m_pressed[d][b] != 0 || m_left[d][b] > 0) ? 1 : 0;
    endtask

    task automatic model_update();
        int h, v, hit, addr, cond, fb, bl, br;
        h = int'(h_cnt);
        v = int'(v_cnt);
        hit = (valid && h >= m_fx && h < m_fx + 16 && v >= m_fy && v < m_fy + 16) ? 1 : 0;
        addr = (hit != 0) ? (v - m_fy) * 16 + (h - m_fx) : 0;
        e_en = p_hit; e_vd = p_valid; e_hd = p_h; e_addr = addr;
        p_hit = hit; p_valid = valid ? 1 : 0; p_h = h;
        cond = (v == 480 && h == 0) ? 1 : 0;
        fb = (cond != 0 && m_prevc == 0) ? 1 : 0;
        m_prevc = cond;
        if (fb != 0) begin
            bl = (m_pend != 0) ? m_pl : m_sl;
            br = (m_pend != 0) ? m_pr : m_sr;
            if (m_pend != 0) begin
                m_fx = m_px; m_fy = m_py; m_sl = m_pl; m_sr = m_pr;
            end
            for (int d = 0; d < 2; d++) begin
                btn_update(d, 0, bl);
                btn_update(d, 1, br);
            end
        end
        if (mouse_event) begin
            m_pend = 1;
            m_px = (int'(mouse_x) > 639) ? 639 : int'(mouse_x);
            m_py = (int'(mouse_y) > 479) ? 479 : int'(mouse_y);
            m_pl = mouse_left ? 1 : 0;
            m_pr = mouse_right ? 1 : 0;
        end else if (fb != 0) begin
            m_pend = 0;
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_update();
        #1;
    endtask

    task automatic set_pix(input int h, input int v);
        h_cnt = 10'(h);
        v_cnt = 10'(v);
        valid = (h < 640 && v < 480);
    endtask

    task automatic send_event(input int x, input int y, input bit l, input bit r);
        mouse_x = 10'(x); mouse_y = 10'(y);
        mouse_left = l; mouse_right = r;
        mouse_event = 1'b1;
        tick();
        mouse_event = 1'b0;
    endtask

    // Two cycles parked on the boundary pixel: the strobe must fire only once
    task automatic frame_boundary();
        set_pix(0, 480);
        tick();
        tick();
        set_pix(0, 0);
        tick();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            h_cnt = 10'($urandom_range(0, 1023)); v_cnt = 10'($urandom_range(0, 1023));
            valid = 1'($urandom); mouse_event = 1'($urandom);
            mouse_x = 10'($urandom_range(0, 1023)); mouse_y = 10'($urandom_range(0, 1023));
            mouse_left = 1'($urandom); mouse_right = 1'($urandom);
            tick();
            checks++;
            if ({bus0.cursor_addr, bus0.enable_mouse_display, bus0.valid_d, bus0.h_cnt_d,
                 bus0.frame_x, bus0.frame_y, bus0.left_flag, bus0.right_flag,
                 bus1.left_flag, bus1.right_flag} !== '0) begin
                errors++;
                $display("FAIL reset_outputs: addr=%0d en=%0d vd=%0d hd=%0d fx=%0d fy=%0d flags=%b%b%b%b, all required 0",
                         bus0.cursor_addr, bus0.enable_mouse_display, bus0.valid_d, bus0.h_cnt_d,
                         bus0.frame_x, bus0.frame_y, bus0.left_flag, bus0.right_flag,
                         bus1.left_flag, bus1.right_flag);
            end
        end
        mouse_event = 1'b0; mouse_left = 1'b0; mouse_right = 1'b0;
        set_pix(0, 0);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_coherency();
        set_pix(300, 200);
        send_event(100, 50, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            set_pix(301 + i, 200);
            tick();
            checks++;
            if (bus0.frame_x !== 10'd0 || bus0.frame_y !== 10'd0) begin
                errors++;
                $display("FAIL coh_midframe: frame=(%0d,%0d) required (0,0)", bus0.frame_x, bus0.frame_y);
            end
        end
        frame_boundary();
        checks++;
        if (bus0.frame_x !== 10'd100 || bus0.frame_y !== 10'd50) begin
            errors++;
            $display("FAIL coh_commit: frame=(%0d,%0d) required (100,50)", bus0.frame_x, bus0.frame_y);
        end
        set_pix(103, 52);
        tick();
        checks++;
        if (bus0.cursor_addr !== 8'd35) begin
            errors++;
            $display("FAIL coh_addr: got %0d required 35", bus0.cursor_addr);
        end
        set_pix(200, 52);
        tick();
        checks++;
        if (bus0.enable_mouse_display !== 1'b1 || bus0.valid_d !== 1'b1 || bus0.h_cnt_d !== 10'd103) begin
            errors++;
            $display("FAIL coh_align: en=%0d vd=%0d hd=%0d required 1,1,103",
                     bus0.enable_mouse_display, bus0.valid_d, bus0.h_cnt_d);
        end
    endtask

    task automatic test_edge_clip();
        send_event(635, 470, 1'b0, 1'b0);
        frame_boundary();
        set_pix(639, 479);
        tick();
        checks++;
        if (bus0.cursor_addr !== 8'd148) begin
            errors++;
            $display("FAIL clip_addr: got %0d required 148", bus0.cursor_addr);
        end
        set_pix(0, 0);
        tick();
        checks++;
        if (bus0.enable_mouse_display !== 1'b1 || bus0.cursor_addr !== 8'd0) begin
            errors++;
            $display("FAIL clip_edge_hit: en=%0d addr=%0d required 1,0",
                     bus0.enable_mouse_display, bus0.cursor_addr);
        end
        tick();
        checks++;
        if (bus0.enable_mouse_display !== 1'b0) begin
            errors++;
            $display("FAIL clip_nowrap: en=%0d required 0", bus0.enable_mouse_display);
        end
        send_event(700, 900, 1'b0, 1'b0);
        frame_boundary();
        checks++;
        if (bus0.frame_x !== 10'd639 || bus0.frame_y !== 10'd479) begin
            errors++;
            $display("FAIL clip_clamp: frame=(%0d,%0d) required (639,479)", bus0.frame_x, bus0.frame_y);
        end
    endtask

    task automatic test_simultaneous();
        set_pix(5, 100);
        send_event(10, 10, 1'b0, 1'b0);
        set_pix(0, 480);
        send_event(20, 20, 1'b0, 1'b0);
        tick();
        set_pix(0, 0);
        tick();
        checks++;
        if (bus0.frame_x !== 10'd10 || bus0.frame_y !== 10'd10) begin
            errors++;
            $display("FAIL simul_first: frame=(%0d,%0d) required (10,10)", bus0.frame_x, bus0.frame_y);
        end
        frame_boundary();
        checks++;
        if (bus0.frame_x !== 10'd20 || bus0.frame_y !== 10'd20) begin
            errors++;
            $display("FAIL simul_second: frame=(%0d,%0d) required (20,20)", bus0.frame_x, bus0.frame_y);
        end
    endtask

    task automatic test_hold();
        set_pix(0, 10);
        send_event(300, 300, 1'b1, 1'b0);
        frame_boundary();
        checks++;
        if (bus0.left_flag !== 1'b1 || bus1.left_flag !== 1'b1) begin
            errors++;
            $display("FAIL hold_press: flags a=%0d b=%0d required 1,1", bus0.left_flag, bus1.left_flag);
        end
        for (int round = 0; round < 2; round++) begin
            send_event(300, 300, 1'b0, 1'b0);
            frame_boundary();
            checks++;
            if (bus0.left_flag !== 1'b1 || bus1.left_flag !== 1'b0) begin
                errors++;
                $display("FAIL hold_release: flags a=%0d b=%0d required 1,0", bus0.left_flag, bus1.left_flag);
            end
            if (round == 0) begin
                // two hold frames, then re-press restarts the sequence
                frame_boundary();
                frame_boundary();
                send_event(300, 300, 1'b1, 1'b0);
                frame_boundary();
                checks++;
                if (bus0.left_flag !== 1'b1 || bus1.left_flag !== 1'b1) begin
                    errors++;
                    $display("FAIL hold_repress: flags a=%0d b=%0d required 1,1", bus0.left_flag, bus1.left_flag);
                end
            end else begin
                for (int f = 1; f <= 4; f++) begin
                    frame_boundary();
                    checks++;
                    if (bus0.left_flag !== 1'((f < 4) ? 1 : 0)) begin
                        errors++;
                        $display("FAIL hold_count: frame %0d after release flag=%0d required %0d",
                                 f, bus0.left_flag, (f < 4) ? 1 : 0);
                    end
                end
            end
        end
        checks++;
        if (bus0.right_flag !== 1'b0) begin
            errors++;
            $display("FAIL hold_right_idle: got %0d required 0", bus0.right_flag);
        end
    endtask

    task automatic test_reset_midframe();
        send_event(50, 60, 1'b0, 1'b1);
        set_pix(25, 25);
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({bus0.cursor_addr, bus0.enable_mouse_display, bus0.valid_d, bus0.h_cnt_d,
             bus0.frame_x, bus0.frame_y, bus0.left_flag, bus0.right_flag} !== '0) begin
            errors++;
            $display("FAIL rst_mid: addr=%0d en=%0d vd=%0d hd=%0d fx=%0d fy=%0d, all required 0",
                     bus0.cursor_addr, bus0.enable_mouse_display, bus0.valid_d, bus0.h_cnt_d,
                     bus0.frame_x, bus0.frame_y);
        end
        tick();
        rst_n = 1'b1;
        tick();
        frame_boundary();
        checks++;
        if (bus0.frame_x !== 10'd0 || bus0.frame_y !== 10'd0 || bus0.right_flag !== 1'b0) begin
            errors++;
            $display("FAIL rst_no_stale: frame=(%0d,%0d) right=%0d required (0,0) 0",
                     bus0.frame_x, bus0.frame_y, bus0.right_flag);
        end
    endtask

    task automatic test_latency_random();
        int h, v, r;
        for (int n = 0; n < 3000; n++) begin
            r = int'($urandom_range(0, 299));
            if (r < 2) begin
                h = 0; v = 480;
            end else if (r < 160) begin
                h = m_fx + int'($urandom_range(0, 21)) - 3;
                v = m_fy + int'($urandom_range(0, 21)) - 3;
                if (h < 0) h = 0;
                if (v < 0) v = 0;
            end else begin
                h = int'($urandom_range(0, 799));
                v = int'($urandom_range(0, 524));
            end
            set_pix(h, v);
            mouse_event = ($urandom_range(0, 39) == 0);
            mouse_x = 10'($urandom_range(0, 1023));
            mouse_y = 10'($urandom_range(0, 1023));
            mouse_left = 1'($urandom);
            mouse_right = 1'($urandom);
            tick();
            checks++;
            if (bus0.cursor_addr !== 8'(e_addr) || bus0.enable_mouse_display !== 1'(e_en) ||
                bus0.valid_d !== 1'(e_vd) || bus0.h_cnt_d !== 10'(e_hd)) begin
                errors++;
                $display("FAIL rnd_pipe @%0d: addr=%0d en=%0d vd=%0d hd=%0d required %0d %0d %0d %0d",
                         n, bus0.cursor_addr, bus0.enable_mouse_display, bus0.valid_d, bus0.h_cnt_d,
                         e_addr, e_en, e_vd, e_hd);
            end
            checks++;
            if (bus0.frame_x !== 10'(m_fx) || bus0.frame_y !== 10'(m_fy) ||
                bus0.left_flag !== 1'(e_flag[0][0]) || bus0.right_flag !== 1'(e_flag[0][1]) ||
                bus1.left_flag !== 1'(e_flag[1][0]) || bus1.right_flag !== 1'(e_flag[1][1])) begin
                errors++;
                $display("FAIL rnd_frame @%0d: fx=%0d fy=%0d flags=%b%b%b%b required %0d %0d %0d%0d%0d%0d",
                         n, bus0.frame_x, bus0.frame_y, bus0.left_flag, bus0.right_flag,
                         bus1.left_flag, bus1.right_flag, m_fx, m_fy,
                         e_flag[0][0], e_flag[0][1], e_flag[1][0], e_flag[1][1]);
            end
            checks++;
            if (bus0.valid_d === 1'b0 && bus0.enable_mouse_display !== 1'b0) begin
                errors++;
                $display("FAIL rnd_en_invalid @%0d: en=%0d while valid_d=0, required 0",
                         n, bus0.enable_mouse_display);
            end
        end
        mouse_event = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_coherency();
        test_edge_clip();
        test_simultaneous();
        test_hold();
        test_reset_midframe();
        test_latency_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
